// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for a bank of hex seven-segment digits.
// Scans one digit per SCAN_DIV-cycle slot and blanks the enables at the start of
// each slot to stop ghosting. The inputs are captured into shadow registers once
// per frame so that a single frame never mixes old and new values.
// Leading zeros can be suppressed, and frame_done pulses once per frame.
// Every output is registered and follows the scan state one cycle later.

module seven_seg_scan #(
  parameter int N_DIG         = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_CYC     = 2,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*N_DIG-1:0] din,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [N_DIG-1:0]   blank,
  input  logic               lzb_en,
  output logic [6:0]         seg,
  output logic               dp,
  output logic [N_DIG-1:0]   an,
  output logic               frame_done
);

  localparam int PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(SCAN_DIV - 1);
  localparam logic [PCNT_W-1:0] PCNT_BLANK = PCNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_DIG - 1);
  localparam logic [N_DIG-1:0]  AN_OFF     = (AN_ACTIVE_LOW != 0) ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

  logic [PCNT_W-1:0]  pcnt;
  logic [IDX_W-1:0]   idx;
  logic               primed;
  logic               wrapped;
  logic [4*N_DIG-1:0] din_s;
  logic [N_DIG-1:0]   dp_s;
  logic [N_DIG-1:0]   blank_s;
  logic               lzb_s;

  logic               tick;
  logic               wrap;
  logic               capture;
  logic               run;
  logic [N_DIG-1:0]   supp;
  logic [3:0]         cur_nib;
  logic               cur_dp;
  logic               cur_dark;
  logic [N_DIG-1:0]   an_sel;
  logic               in_blank;
  logic [6:0]         seg_nxt;
  logic               dp_nxt;
  logic [N_DIG-1:0]   an_nxt;

  // The lookup covers the hex digits 0..F. Segments are active-low, in the order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick    = (pcnt == PCNT_LAST);
  assign wrap    = tick && (idx == IDX_LAST);
  assign capture = !primed || wrap;

  // Slot prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

  // Frame-coherent shadow capture: once just after reset, then at every frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed  <= 1'b0;
      wrapped <= 1'b0;
      din_s   <= '0;
      dp_s    <= '0;
      blank_s <= '0;
      lzb_s   <= 1'b0;
    end else begin
      primed  <= 1'b1;
      wrapped <= wrap;
      if (capture) begin
        din_s   <= din;
        dp_s    <= dp_in;
        blank_s <= blank;
        lzb_s   <= lzb_en;
      end
    end
  end

  // Leading-zero suppression, scanned from the top digit downward; digit 0 is never suppressed
  always_comb begin
    run  = lzb_s;
    supp = '0;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      run     = run & (din_s[4*k +: 4] == 4'h0);
      supp[k] = run;
    end
  end

  // Select the shadow values for the digit currently being scanned
  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    an_sel   = '0;
    for (int k = 0; k < N_DIG; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib   = din_s[4*k +: 4];
        cur_dp    = dp_s[k];
        cur_dark  = blank_s[k] | supp[k];
        an_sel[k] = 1'b1;
      end
    end
  end

  // Next output values. A dark digit keeps its enable and its decimal point.
  always_comb begin
    in_blank = (pcnt < PCNT_BLANK);
    seg_nxt  = cur_dark ? 7'h7F : hex2seg(cur_nib);
    dp_nxt   = ~cur_dp;
    if (in_blank)
      an_nxt = AN_OFF;
    else if (AN_ACTIVE_LOW != 0)
      an_nxt = ~an_sel;
    else
      an_nxt = an_sel;
  end

  // Output registers, one cycle behind the scan state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      an         <= an_nxt;
      frame_done <= wrapped;
    end
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed driver for a common-anode/cathode bank of N_DIG hex seven-segment digits. It sits between the datapath (packed hex nibbles, decimal points, per-digit blanks) and the board's shared segment bus plus per-digit enables. It adds digit scanning, frame-coherent input capture, anti-ghosting blanking, leading-zero suppression and a frame strobe.

## Interface
- N_DIG, 4: number of digits, 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot, at least 2.
- BLANK_CYC, 2: cycles at the start of each slot with all enables off, less than SCAN_DIV.
- AN_ACTIVE_LOW, 1: 1 means `an` is active-low; 0 means active-high.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- din  in  4*N_DIG  hex nibbles; digit k is din[4k+3:4k], with digit 0 rightmost.
- dp_in  in  N_DIG  decimal point request per digit, 1 = lit.
- blank  in  N_DIG  force digit dark, 1 = dark.
- lzb_en  in  1  leading-zero blanking enable.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, 1 = off.
- dp  out  1  decimal point, active-low.
- an  out  N_DIG  digit enables, polarity per AN_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse when digit N_DIG-1 slot ends.

## Operation
- Hex table for seg, in order 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Prescaler `pcnt` counts 0..SCAN_DIV-1. `tick` is asserted when pcnt == SCAN_DIV-1; pcnt then wraps to 0.
- Digit index `idx` runs 0..N_DIG-1. It advances on tick and wraps N_DIG-1 to 0.
- Shadow registers capture din, dp_in, blank and lzb_en:
  - on the first clock after reset release (a `primed` flag, cleared by reset);
  - on every tick where idx wraps to 0.
  - Inputs changing mid-frame never cause tearing.
- Leading-zero blanking, computed on shadow values:
  - digit k ≥ 1 is suppressed when lzb_en=1 and shadow nibbles k..N_DIG-1 are all 0;
  - digit 0 is never suppressed by LZB;
  - the dp of a suppressed digit is still honoured.
- Dark digit (shadow blank[k] or LZB-suppressed): seg = 7'h7F. `an` is still driven for the slot, dp follows shadow dp_in[k].
- Slot-phase blanking: during pcnt < BLANK_CYC, all `an` are inactive; seg and dp already carry the new digit.
- Outside the blank phase, exactly one `an` bit is active, at position idx.
- N_DIG=1: idx is constant 0, frame_done pulses every SCAN_DIV cycles, and the shadow reloads every slot.

## Timing
- Reset values: seg=7'h7F, dp=1, an all inactive, frame_done=0, pcnt=0, idx=0, shadow=0, primed=0.
- All outputs are registered and reflect the pcnt/idx state of the previous cycle (1-cycle latency).
- The first edge after rst_n rises captures the shadow.
- From rst_n release to the first active `an` (digit 0) takes BLANK_CYC+1 cycles.
- Each slot is exactly SCAN_DIV cycles; a frame is N_DIG*SCAN_DIV cycles.
- frame_done is high for the one output cycle following the tick with idx = N_DIG-1. That is the same cycle in which `an` goes inactive for digit 0's blank phase.
- Input change to display change takes at most one frame plus 1 cycle.
- rst_n asserted mid-slot forces all reset values immediately and asynchronously. No partial frame completes, and the next frame starts at digit 0.
- Wrap and shadow capture happen on the same edge, so the new frame's digit 0 uses the new shadow.

## Test plan
- N_DIG=4, SCAN_DIV=4, BLANK_CYC=1, AN_ACTIVE_LOW=1; din=16'h12AF, lzb_en=0 -> slots in order:
  - digit 0: seg=0001110, an=1110 on cycles 2-4;
  - digit 1: seg=0001000, an=1101;
  - digit 2: seg=0100100, an=1011;
  - digit 3: seg=1111001, an=0111;
  - an=1111 in each slot's first cycle; frame_done pulses every 16 cycles.
- All 16 nibbles on digit 0 -> seg matches the table above exactly; dp_in=4'b0001 -> dp=0 only during digit 0 slots.
- din=16'h0007, lzb_en=1 -> digits 3..1 seg=1111111 with an still scanning, digit 0 seg=1111000. din=16'h0000 -> digit 0 shows 1000000.
- din changed from 16'h1111 to 16'h2222 mid-frame (during digit 1 slot) -> remainder of the frame shows 1; digit 0 of the next frame onward shows 2. No mixed frame.
- blank=4'b0100, din=16'h8888 -> digit 2 seg=7'h7F with an active; other digits seg=0000000.
- rst_n pulsed low during digit 2 slot -> outputs immediately at reset values; after release, digit 0 is active after BLANK_CYC+1 cycles and frame_done occurs 16 cycles after the first capture.
